wb_uart_fifo: RTL and testbench

- Wishbone slave UART with TX and RX FIFOs, programmable baud divisor and a level interrupt.
- Sits downstream of the wb_conbus_top slave port currently used by uart0 (15'h7000). Replaces the unbuffered UART on that port.
- Its intr output drives intr_n[0] through the existing inversion.
- Frame format is 8N1, LSB first, with 16x oversampled receive.

---
 rtl/wb_uart_fifo.sv | 348 ++++++++++++++++++++++++++++++++++
 tb/tb_wb_uart_fifo.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_fifo.sv
// Wishbone UART with 8N1 TX/RX FIFOs, programmable baud divisor and a level
// interrupt. Receive path is 16x oversampled behind a 2-FF synchronizer.
module wb_uart_fifo #(
    parameter int clk_freq        = 50000000,
    parameter int baud            = 115200,
    parameter int fifo_depth_log2 = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    output logic        intr,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    localparam int DEPTH   = 2 ** fifo_depth_log2;
    localparam int AW      = fifo_depth_log2;
    localparam int CW      = fifo_depth_log2 + 1;
    localparam int DIV_RAW = clk_freq / (16 * baud);

    localparam logic [15:0]   RESET_DIV = (DIV_RAW < 1) ? 16'd1 : 16'(DIV_RAW);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    typedef enum logic [1:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
    } rx_state_t;

    // ---------------- bus decode ----------------
    logic       req;
    logic [1:0] reg_sel;
    logic       wr_en;
    logic       rd_en;
    logic       data_wr;
    logic       stat_wr;
    logic       ctrl_wr;
    logic       div_wr;
    logic       data_rd;

    assign req     = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign reg_sel = wb_adr_i[3:2];
    assign wr_en   = req & wb_we_i & wb_sel_i[0];
    assign rd_en   = req & ~wb_we_i;
    assign data_wr = wr_en & (reg_sel == 2'd0);
    assign stat_wr = wr_en & (reg_sel == 2'd1);
    assign ctrl_wr = wr_en & (reg_sel == 2'd2);
    assign div_wr  = wr_en & (reg_sel == 2'd3);
    assign data_rd = rd_en & (reg_sel == 2'd0);

    logic unused;
    assign unused = &{1'b0, wb_adr_i[31:4], wb_adr_i[1:0],
                      wb_dat_i[31:16], wb_sel_i[3:1]};

    // ---------------- baud tick ----------------
    logic [15:0] div;
    logic [15:0] bcnt;
    logic        tick16;

    assign tick16 = (bcnt == div - 16'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div  <= RESET_DIV;
            bcnt <= '0;
        end else if (div_wr) begin
            div  <= (wb_dat_i[15:0] == 16'd0) ? 16'd1 : wb_dat_i[15:0];
            bcnt <= '0;
        end else if (tick16) begin
            bcnt <= '0;
        end else begin
            bcnt <= bcnt + 16'd1;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wp;
    logic [AW-1:0] tx_rp;
    logic [CW-1:0] tx_cnt;
    logic          tx_full;
    logic          tx_empty;
    logic          tx_push;
    logic          tx_pop;
    logic          tx_ovf_set;

    tx_state_t tx_state;
    logic [3:0] tx_tcnt;
    logic [2:0] tx_bit;
    logic [7:0] tx_sh;

    assign tx_full    = (tx_cnt == FULL_CNT);
    assign tx_empty   = (tx_cnt == '0);
    assign tx_pop     = tick16 & ~tx_empty &
                        ((tx_state == TX_IDLE) |
                         ((tx_state == TX_STOP) & (tx_tcnt == 4'hF)));
    assign tx_push    = data_wr & (~tx_full | tx_pop);
    assign tx_ovf_set = data_wr & tx_full & ~tx_pop;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= wb_dat_i[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            unique case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // ---------------- TX FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TX_IDLE;
            tx_tcnt  <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            uart_txd <= 1'b1;
        end else begin
            unique case (tx_state)
                TX_IDLE: begin
                    uart_txd <= 1'b1;
                    if (tx_pop) begin
                        tx_state <= TX_START;
                        tx_sh    <= tx_mem[tx_rp];
                        tx_tcnt  <= '0;
                        uart_txd <= 1'b0;
                    end
                end
                TX_START: if (tick16) begin
                    tx_tcnt <= tx_tcnt + 4'd1;
                    if (tx_tcnt == 4'hF) begin
                        tx_state <= TX_DATA;
                        tx_bit   <= '0;
                        uart_txd <= tx_sh[0];
                    end
                end
                TX_DATA: if (tick16) begin
                    tx_tcnt <= tx_tcnt + 4'd1;
                    if (tx_tcnt == 4'hF) begin
                        if (tx_bit == 3'd7) begin
                            tx_state <= TX_STOP;
                            uart_txd <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_sh    <= {1'b0, tx_sh[7:1]};
                            uart_txd <= tx_sh[1];
                        end
                    end
                end
                TX_STOP: if (tick16) begin
                    tx_tcnt <= tx_tcnt + 4'd1;
                    if (tx_tcnt == 4'hF) begin
                        // Chain straight into the next start bit when data waits.
                        if (tx_pop) begin
                            tx_state <= TX_START;
                            tx_sh    <= tx_mem[tx_rp];
                            uart_txd <= 1'b0;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // ---------------- RX sync + FSM ----------------
    logic rx_s1;
    logic rx_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= uart_rxd;
            rx_s2 <= rx_s1;
        end
    end

    rx_state_t rx_state;
    logic [3:0] rx_tcnt;
    logic [2:0] rx_bit;
    logic [7:0] rx_sh;
    logic       rx_frame_end;

    assign rx_frame_end = tick16 & (rx_state == RX_STOP) & (rx_tcnt == 4'hF);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state <= RX_IDLE;
            rx_tcnt  <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            unique case (rx_state)
                RX_IDLE: if (tick16 && !rx_s2) begin
                    rx_state <= RX_START;
                    rx_tcnt  <= '0;
                end
                RX_START: if (tick16) begin
                    rx_tcnt <= rx_tcnt + 4'd1;
                    if (rx_tcnt == 4'd7) begin
                        rx_tcnt  <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: if (tick16) begin
                    rx_tcnt <= rx_tcnt + 4'd1;
                    if (rx_tcnt == 4'hF) begin
                        rx_sh  <= {rx_s2, rx_sh[7:1]};
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end
                end
                RX_STOP: if (tick16) begin
                    rx_tcnt <= rx_tcnt + 4'd1;
                    if (rx_tcnt == 4'hF) begin
                        rx_state <= rx_s2 ? RX_IDLE : RX_WAIT;
                    end
                end
                RX_WAIT: if (rx_s2) rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wp;
    logic [AW-1:0] rx_rp;
    logic [CW-1:0] rx_cnt;
    logic          rx_full;
    logic          rx_avail;
    logic          rx_push_req;
    logic          rx_push;
    logic          rx_pop;
    logic          rx_ovr_set;
    logic          frame_err_set;

    assign rx_full       = (rx_cnt == FULL_CNT);
    assign rx_avail      = (rx_cnt != '0);
    assign rx_pop        = data_rd & rx_avail;
    assign rx_push_req   = rx_frame_end & rx_s2;
    assign rx_push       = rx_push_req & (~rx_full | rx_pop);
    assign rx_ovr_set    = rx_push_req & rx_full & ~rx_pop;
    assign frame_err_set = rx_frame_end & ~rx_s2;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp] <= rx_sh;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            unique case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // ---------------- registers ----------------
    logic rx_ovr;
    logic frame_err;
    logic tx_ovf;
    logic rx_ie;
    logic tx_ie;
    logic tx_idle;

    assign tx_idle = tx_empty & (tx_state == TX_IDLE);

    // A set event in the same cycle as a write-1-to-clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_ovr    <= 1'b0;
            frame_err <= 1'b0;
            tx_ovf    <= 1'b0;
            rx_ie     <= 1'b0;
            tx_ie     <= 1'b0;
        end else begin
            rx_ovr    <= (rx_ovr & ~(stat_wr & wb_dat_i[3])) | rx_ovr_set;
            frame_err <= (frame_err & ~(stat_wr & wb_dat_i[4])) | frame_err_set;
            tx_ovf    <= (tx_ovf & ~(stat_wr & wb_dat_i[5])) | tx_ovf_set;
            if (ctrl_wr) begin
                rx_ie <= wb_dat_i[0];
                tx_ie <= wb_dat_i[1];
            end
        end
    end

    logic [31:0] status_w;
    logic [31:0] rd_data;

    always_comb begin
        status_w       = '0;
        status_w[15:8] = 8'(rx_cnt);
        status_w[5:0]  = {tx_ovf, frame_err, rx_ovr, tx_idle, tx_full, rx_avail};
        rd_data        = '0;
        unique case (reg_sel)
            2'd0:    rd_data = rx_avail ? {23'd0, 1'b1, rx_mem[rx_rp]} : 32'd0;
            2'd1:    rd_data = status_w;
            2'd2:    rd_data = {30'd0, tx_ie, rx_ie};
            2'd3:    rd_data = {16'd0, div};
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            intr     <= 1'b0;
        end else begin
            wb_ack_o <= req;
            if (rd_en) wb_dat_o <= rd_data;
            intr <= (rx_ie & rx_avail) | (tx_ie & tx_idle);
        end
    end

endmodule

// File: tb/tb_wb_uart_fifo.sv
// Randomized self-checking bench for wb_uart_fifo: bus accesses, serial
// frame decode/encode and queue-based FIFO models.
module tb_wb_uart_fifo;

    localparam int CLK_FREQ = 50000000;
    localparam int BAUD     = 115200;
    localparam int EXP_DIV  = CLK_FREQ / (16 * BAUD);
    localparam int DEPTH    = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic        wb_ack_o;
    logic        intr;
    logic        uart_rxd;
    logic        uart_txd;

    logic tb_rxd  = 1'b1;
    logic loop_en = 1'b0;

    assign uart_rxd = loop_en ? uart_txd : tb_rxd;

    wb_uart_fifo #(
        .clk_freq        (CLK_FREQ),
        .baud            (BAUD),
        .fifo_depth_log2 (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_sel_i (wb_sel_i),
        .wb_stb_i (wb_stb_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_we_i  (wb_we_i),
        .wb_ack_o (wb_ack_o),
        .intr     (intr),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int bitclk   = 16 * EXP_DIV;

    logic [8:0] tx_seen [$];
    logic [7:0] exp_tx  [$];
    logic [7:0] exp_rx  [$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_cycle(input logic we, input logic [1:0] a,
                            input logic [31:0] wd, input logic [3:0] sel,
                            output logic [31:0] rd);
        int n = 0;
        @(posedge clk); #1;
        wb_adr_i = {28'd0, a, 2'b00};
        wb_dat_i = wd;
        wb_we_i  = we;
        wb_sel_i = sel;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!wb_ack_o && n < 8);
        check("ack", wb_ack_o, 1'b1);
        rd       = wb_dat_o;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic wb_wr(input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] dummy;
        logic [3:0] sel = {3'($urandom), 1'b1};
        wb_cycle(1'b1, a, wd, sel, dummy);
    endtask

    task automatic wb_rd(input logic [1:0] a, output logic [31:0] rd);
        wb_cycle(1'b0, a, 32'd0, 4'hF, rd);
    endtask

    task automatic wait_txd_low(input string tag);
        int n = 0;
        while (uart_txd === 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, uart_txd, 1'b0);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        @(posedge clk); #1;
        tb_rxd = 1'b0;
        repeat (bitclk) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            tb_rxd = b[i];
            repeat (bitclk) @(posedge clk);
            #1;
        end
        tb_rxd = stop_bit;
        repeat (bitclk) @(posedge clk);
        #1;
        tb_rxd = 1'b1;
    endtask

    task automatic check_tx_seen(input string tag);
        int n = (tx_seen.size() < exp_tx.size()) ? tx_seen.size() : exp_tx.size();
        check({tag, "_nframes"}, tx_seen.size(), exp_tx.size());
        for (int i = 0; i < n; i++)
            check($sformatf("%s_frame%0d", tag, i), tx_seen[i], {1'b1, exp_tx[i]});
        tx_seen.delete();
        exp_tx.delete();
    endtask

    // Serial decoder on uart_txd: samples each bit at its midpoint.
    initial begin
        forever begin
            logic [8:0] f;
            @(negedge clk);
            if (reset_n === 1'b1 && uart_txd === 1'b0) begin
                repeat (bitclk / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (bitclk) @(negedge clk);
                    f[i] = uart_txd;
                end
                repeat (bitclk) @(negedge clk);
                f[8] = uart_txd;
                tx_seen.push_back(f);
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  b;
        logic [7:0]  got;
        logic        stop;
        int          len;
        int          d;
        int          fifo_n;
        logic        ovf;

        reset_n  = 1'b0;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_sel_i = '0;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // reset state
        check("rst_ack", wb_ack_o, 1'b0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_intr", intr, 1'b0);
        check("rst_txd", uart_txd, 1'b1);
        wb_rd(2'd1, rd);
        check("rst_status", rd, 32'h4);
        @(posedge clk); #1;
        check("ack_one_cycle", wb_ack_o, 1'b0);
        wb_rd(2'd3, rd);
        check("rst_div", rd, EXP_DIV);
        wb_rd(2'd2, rd);
        check("rst_ctrl", rd, 32'd0);
        wb_rd(2'd0, rd);
        check("rst_data_empty", rd, 32'd0);

        // TX 0x55 at the reset divisor
        wb_wr(2'd0, 32'h55);
        exp_tx.push_back(8'h55);
        wait_txd_low("t1_start");
        len = 0;
        while (uart_txd === 1'b0 && len < 1000) begin
            @(posedge clk); #1;
            len++;
        end
        check("t1_bit_len", len, 16 * EXP_DIV);
        repeat (bitclk / 2) @(posedge clk);
        #1 got[0] = uart_txd;
        for (int i = 1; i < 8; i++) begin
            repeat (bitclk) @(posedge clk);
            #1 got[i] = uart_txd;
        end
        repeat (bitclk) @(posedge clk);
        #1 stop = uart_txd;
        check("t1_data_bits", got, 8'h55);
        check("t1_stop_bit", stop, 1'b1);
        wb_rd(2'd1, rd);
        check("t1_busy", rd, 32'h0);
        repeat (230) @(posedge clk);
        wb_rd(2'd1, rd);
        check("t1_idle", rd, 32'h4);

        // divisor programming
        wb_wr(2'd3, 32'd0);
        wb_rd(2'd3, rd);
        check("div_zero", rd, 32'd1);
        d = $urandom_range(1, 3);
        wb_wr(2'd3, d);
        bitclk = 16 * d;
        wb_rd(2'd3, rd);
        check("div_set", rd, d);

        // loopback
        loop_en = 1'b1;
        exp_tx.push_back(8'hA5);
        exp_tx.push_back(8'h3C);
        wb_wr(2'd0, 32'hA5);
        wb_wr(2'd0, 32'h3C);
        repeat (24 * bitclk) @(posedge clk);
        wb_rd(2'd1, rd);
        check("lb_status", rd, 32'h0205);
        wb_rd(2'd0, rd);
        check("lb_rd0", rd, 32'h1A5);
        wb_rd(2'd0, rd);
        check("lb_rd1", rd, 32'h13C);
        wb_rd(2'd0, rd);
        check("lb_rd_empty", rd, 32'h0);
        loop_en = 1'b0;
        check_tx_seen("lb_tx");

        // TX overflow while the FSM is busy on the first frame
        b = 8'($urandom);
        exp_tx.push_back(b);
        wb_wr(2'd0, b);
        wait_txd_low("ovf_start");
        fifo_n = 0;
        ovf    = 1'b0;
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            wb_wr(2'd0, b);
            if (fifo_n < DEPTH) begin
                exp_tx.push_back(b);
                fifo_n++;
            end else begin
                ovf = 1'b1;
            end
        end
        wb_rd(2'd1, rd);
        check("ovf_status", rd, {26'd0, ovf, 3'b000, fifo_n == DEPTH, 1'b0});
        wb_wr(2'd1, 32'h20);
        wb_rd(2'd1, rd);
        check("ovf_clear", rd, 32'h02);
        repeat (18 * 10 * bitclk) @(posedge clk);
        check_tx_seen("ovf_tx");
        wb_rd(2'd1, rd);
        check("ovf_drained", rd, 32'h04);

        // RX overrun: 17 frames, no reads
        ovf = 1'b0;
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            if (exp_rx.size() < DEPTH) exp_rx.push_back(b);
            else ovf = 1'b1;
            repeat ($urandom_range(0, bitclk)) @(posedge clk);
            send_rx(b, 1'b1);
        end
        repeat (4) @(posedge clk);
        wb_rd(2'd1, rd);
        check("ovr_status", rd,
              {16'd0, 8'(exp_rx.size()), 4'd0, ovf, 1'b1, 1'b0, 1'b1});
        while (exp_rx.size() > 0) begin
            b = exp_rx.pop_front();
            wb_rd(2'd0, rd);
            check("ovr_rd", rd, {23'd0, 1'b1, b});
        end
        wb_rd(2'd0, rd);
        check("ovr_rd_empty", rd, 32'd0);
        wb_wr(2'd1, 32'h08);
        wb_rd(2'd1, rd);
        check("ovr_clear", rd, 32'h04);

        // framing error and start glitch
        send_rx(8'($urandom), 1'b0);
        repeat (4 * d + 8) @(posedge clk);
        wb_rd(2'd1, rd);
        check("ferr_status", rd, 32'h14);
        wb_wr(2'd1, 32'h10);
        wb_rd(2'd1, rd);
        check("ferr_clear", rd, 32'h04);
        @(posedge clk); #1;
        tb_rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1 tb_rxd = 1'b1;
        repeat (20 * bitclk) @(posedge clk);
        wb_rd(2'd1, rd);
        check("glitch_status", rd, 32'h04);

        // interrupt
        wb_wr(2'd2, 32'h1);
        wb_cycle(1'b1, 2'd2, 32'h3, 4'hE, rd);
        wb_rd(2'd2, rd);
        check("ctrl_sel0_gate", rd, 32'h1);
        check("intr_idle", intr, 1'b0);
        b = 8'($urandom);
        send_rx(b, 1'b1);
        check("intr_rx", intr, 1'b1);
        wb_rd(2'd0, rd);
        check("intr_rd", rd, {23'd0, 1'b1, b});
        check("intr_ack_cycle", intr, 1'b1);
        @(posedge clk); #1;
        check("intr_cleared", intr, 1'b0);
        wb_wr(2'd2, 32'h2);
        repeat (2) @(posedge clk);
        #1 check("intr_tx_idle", intr, 1'b1);
        wb_wr(2'd2, 32'h0);
        repeat (2) @(posedge clk);
        #1 check("intr_off", intr, 1'b0);

        // reset mid-frame
        for (int i = 0; i < 3; i++) wb_wr(2'd0, 32'($urandom));
        wait_txd_low("rst_mid_start");
        repeat (bitclk + 3) @(posedge clk);
        #1 reset_n = 1'b0;
        #2 check("rst_mid_txd", uart_txd, 1'b1);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (50) @(posedge clk);
        #1 check("rst_mid_txd_hold", uart_txd, 1'b1);
        wb_rd(2'd1, rd);
        check("rst_mid_status", rd, 32'h04);
        wb_rd(2'd3, rd);
        check("rst_mid_div", rd, EXP_DIV);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
